// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: 16x32 register file with a three-state issue/capture sequencer for an external registered ALU
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        ext_we,
    input  logic [3:0]  ext_addr,
    input  logic [31:0] ext_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_funct,
    input  logic [31:0] alu_res,
    output logic        done,
    output logic [31:0] done_data,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    state_t      state, state_nx;
    logic [31:0] rf [16];
    logic [3:0]  funct_q, rd_q, rs_q, rt_q;
    logic [4:0]  shamt_q;
    logic        accept, legal, unused_ok;
    assign accept      = instr_valid && instr_ready;
    assign legal       = instr[31:28] inside {[4'd1:4'd9]};
    assign instr_ready = rst_n && state == IDLE;
    assign busy        = state != IDLE;
    assign unused_ok   = ^instr[10:0];
    // next state and ALU operand drive; operands are only non-zero during ISSUE
    always_comb begin
        state_nx  = state == IDLE ? (accept && legal ? ISSUE : IDLE) :
                    state == ISSUE ? CAPTURE : IDLE;
        alu_a     = state == ISSUE ? rf[rs_q] : '0;
        alu_b     = state == ISSUE ? rf[rt_q] : '0;
        alu_shamt = state == ISSUE ? shamt_q : '0;
        alu_funct = state == ISSUE ? funct_q : '0;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // instruction fields captured at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct_q <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            shamt_q <= '0;
        end else if (accept) begin
            funct_q <= instr[31:28];
            rd_q    <= instr[27:24];
            rs_q    <= instr[23:20];
            rt_q    <= instr[19:16];
            shamt_q <= instr[15:11];
        end
    end
    // register file: writeback at the end of CAPTURE, preload only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (state == CAPTURE) begin
            rf[rd_q] <= alu_res;
        end else if (state == IDLE && ext_we) begin
            rf[ext_addr] <= ext_data;
        end
    end
    // completion and rejection pulses; done_data holds the last writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            err       <= 1'b0;
            done_data <= '0;
        end else begin
            done      <= state == CAPTURE;
            err       <= accept && !legal;
            done_data <= state == CAPTURE ? alu_res : done_data;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl against a register-array reference model
module tb_alu_issue_ctrl;
    logic        clk = 0, rst_n = 0, instr_valid = 0, ext_we = 0;
    logic [31:0] instr = 0, ext_data = 0, alu_res = 0;
    logic [3:0]  ext_addr = 0;
    logic        instr_ready, done, err, busy;
    logic [31:0] alu_a, alu_b, done_data;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_funct;
    int          n_chk = 0, n_pass = 0;
    logic [31:0] m [16];
    logic [31:0] done_q [$];

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_res(alu_res), .done(done), .done_data(done_data), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [31:0] a, b, input logic [4:0] sh);
        case (f)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return ~b;
            4'd7: return a << sh;
            4'd8: return $signed(a) >>> sh;
            4'd9: return a >> sh;
            default: return 32'h0;
        endcase
    endfunction

    // external ALU: registers its result, holds while funct is 0
    always @(posedge clk) if (alu_funct != 0) alu_res <= alu_f(alu_funct, alu_a, alu_b, alu_shamt);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (done) done_q.push_back(done_data);
        if (done || err) chk("done_err_excl", {31'b0, done & err}, 0);
    end

    function automatic logic [31:0] enc(input logic [3:0] f, rd, rs, rt, input logic [4:0] sh);
        return {f, rd, rs, rt, sh, 11'($urandom)};
    endfunction

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ext_we = 1; ext_addr = a; ext_data = d;
        @(negedge clk);
        ext_we = 0;
        m[a] = d;
    endtask

    task automatic issue(input logic [3:0] f, rd, rs, rt, input logic [4:0] sh,
                         input bit we_acc, input bit we_iss, input logic [31:0] wd);
        logic [31:0] exp;
        @(negedge clk);
        chk("ready_pre", instr_ready, 1);
        chk("done_idle", done, 0);
        instr_valid = 1; instr = enc(f, rd, rs, rt, sh);
        if (we_acc) begin ext_we = 1; ext_addr = rs; ext_data = wd; end
        @(negedge clk);
        instr_valid = 0; ext_we = 0;
        if (we_acc) m[rs] = wd;
        if (!(f inside {[4'd1:4'd9]})) begin
            chk("ill_err", err, 1);
            chk("ill_busy", busy, 0);
            chk("ill_ready", instr_ready, 1);
            chk("ill_funct", alu_funct, 0);
            @(negedge clk);
            chk("ill_err_fall", err, 0);
            chk("ill_done", done, 0);
            chk("ill_busy2", busy, 0);
            return;
        end
        chk("iss_busy", busy, 1);
        chk("iss_ready", instr_ready, 0);
        chk("iss_err", err, 0);
        chk("iss_funct", alu_funct, f);
        chk("iss_a", alu_a, m[rs]);
        chk("iss_b", alu_b, m[rt]);
        chk("iss_shamt", alu_shamt, sh);
        exp = alu_f(f, m[rs], m[rt], sh);
        if (we_iss) begin ext_we = 1; ext_addr = rs; ext_data = wd; end
        @(negedge clk);
        ext_we = 0;
        chk("cap_busy", busy, 1);
        chk("cap_funct", alu_funct, 0);
        chk("cap_a", alu_a, 0);
        chk("cap_done", done, 0);
        @(negedge clk);
        chk("wb_done", done, 1);
        chk("wb_data", done_data, exp);
        chk("wb_busy", busy, 0);
        chk("wb_ready", instr_ready, 1);
        m[rd] = exp;
    endtask

    initial begin
        int acc;
        int acc_at [2];
        for (int i = 0; i < 16; i++) m[i] = 0;
        #2;
        chk("rst_ready", instr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_data", done_data, 0);
        chk("rst_alu", {alu_a ^ alu_b, 3'b0, alu_shamt, alu_funct}, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("rel_ready", instr_ready, 1);
        // ADD and readback of r3 through alu_a
        preload(1, 5); preload(2, 7);
        issue(1, 3, 1, 2, 0, 0, 0, 0);
        chk("add_r3", m[3], 12);
        issue(4, 8, 3, 3, 0, 0, 0, 0);
        // arithmetic vs logical right shift
        preload(4, 32'h8000_0000);
        issue(8, 5, 4, 0, 4, 0, 0, 0);
        chk("sra_val", done_data, 32'hF800_0000);
        issue(9, 5, 4, 0, 4, 0, 0, 0);
        chk("srl_val", done_data, 32'h0800_0000);
        // illegal funct
        issue(12, 6, 1, 2, 0, 0, 0, 0);
        issue(0, 6, 1, 2, 0, 0, 0, 0);
        // chained with instr_valid held high
        preload(1, 3); preload(2, 0);
        done_q.delete();
        acc = 0;
        @(negedge clk);
        instr_valid = 1; instr = enc(1, 1, 1, 1, 0);
        for (int c = 0; c < 20 && acc < 2; c++) begin
            if (instr_ready) begin acc_at[acc] = c; acc++; end
            @(negedge clk);
            if (acc == 1) instr = enc(5, 3, 1, 2, 0);
            else if (acc == 2) instr_valid = 0;
        end
        instr_valid = 0;
        repeat (4) @(negedge clk);
        chk("chain_acc", acc, 2);
        if (acc == 2) chk("chain_gap", acc_at[1] - acc_at[0], 3);
        chk("chain_ndone", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("chain_r1", done_q[0], 6);
            chk("chain_xor", done_q[1], 6);
        end
        m[1] = 6; m[3] = 6;
        // ext_we during ISSUE ignored; ext_we at accept is seen
        issue(1, 9, 1, 2, 0, 0, 1, 99);
        issue(4, 10, 1, 1, 0, 0, 0, 0);
        issue(2, 11, 7, 7, 0, 1, 0, 32'h1234);
        issue(1, 7, 7, 1, 0, 0, 0, 0);
        // reset during CAPTURE
        @(negedge clk);
        instr_valid = 1; instr = enc(1, 6, 1, 2, 0);
        @(negedge clk);
        instr_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_ready", instr_ready, 0);
        chk("ab_funct", alu_funct, 0);
        chk("ab_done", done, 0);
        for (int i = 0; i < 16; i++) m[i] = 0;
        @(negedge clk);
        chk("ab_done2", done, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ab_ready_rel", instr_ready, 1);
        chk("ab_done3", done, 0);
        issue(4, 12, 1, 6, 0, 0, 0, 0);
        issue(4, 12, 3, 7, 0, 0, 0, 0);
        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(1, 0) == 1) preload(4'($urandom), $urandom);
            issue(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 5'($urandom),
                  $urandom_range(4, 0) == 0, $urandom_range(4, 0) == 0, $urandom);
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: instr_valid  input  1  instruction offered.
REQ-005 Port: instr_ready  output  1  block can accept an instruction.
REQ-006 Port: instr  input  32  fields: [31:28] funct, [27:24] rd, [23:20] rs, [19:16] rt, [15:11] shamt, [10:0] ignored.
REQ-007 Port: ext_we  input  1  register-file preload write enable.
REQ-008 Port: ext_addr  input  4  preload address.
REQ-009 Port: ext_data  input  32  preload data.
REQ-010 Port: alu_a  output  32  ALU operand a.
REQ-011 Port: alu_b  output  32  ALU operand b.
REQ-012 Port: alu_shamt  output  5  ALU shift amount.
REQ-013 Port: alu_funct  output  4  ALU function code (1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 SLA, 8 SRA, 9 SRL).
REQ-014 Port: alu_res  input  32  ALU result, registered by the ALU on the rising clk edge.
REQ-015 Port: done  output  1  one-cycle pulse: writeback completed.
REQ-016 Port: done_data  output  32  value written back, held until the next done.
REQ-017 Port: err  output  1  one-cycle pulse: illegal funct rejected.
REQ-018 Port: busy  output  1  high in ISSUE and CAPTURE.

Function
REQ-019 The block SHALL contain a 16 x 32-bit register file written only by ext_we or by writeback.
REQ-020 The FSM SHALL have the states IDLE, ISSUE and CAPTURE.
REQ-021 instr_ready SHALL be 1 only in IDLE.
REQ-022 Accept SHALL occur on instr_valid && instr_ready at a rising edge; instr fields are latched internally at that edge.
REQ-023 An accepted funct of 0 or 10-15 SHALL leave the FSM in IDLE, pulse err in the next cycle, and leave the register file untouched.
REQ-024 An accepted legal funct SHALL move the FSM IDLE -> ISSUE.
REQ-025 In ISSUE, alu_a = rf[rs], alu_b = rf[rt], alu_shamt = latched shamt and alu_funct = latched funct, driven combinationally from the register file and the latched fields.
REQ-026 ISSUE SHALL last exactly one cycle and then go to CAPTURE.
REQ-027 Outside ISSUE, alu_funct SHALL be 0 so that the ALU holds its result, and alu_a, alu_b and alu_shamt SHALL be 0.
REQ-028 On the edge that ends CAPTURE: rf[rd] <= alu_res, done_data <= alu_res, done <= 1, and the FSM returns to IDLE.
REQ-029 Latency SHALL be: accept at edge T; done high from edge T+2 to edge T+3; a new instruction is acceptable at edge T+3.
REQ-030 ext_we SHALL take effect only in IDLE and SHALL be ignored in ISSUE and CAPTURE.
REQ-031 An ext_we at the accept edge SHALL be written, and the new value SHALL be seen by ISSUE when ext_addr equals rs or rt.
REQ-032 rd equal to rs or rt SHALL be legal; the operands are the old values and the register is overwritten at the end of CAPTURE.
REQ-033 Back-to-back instructions SHALL see the previous writeback, because operands are read in ISSUE, after the previous CAPTURE.
REQ-034 NOT (funct 6) SHALL still issue rf[rs] on alu_a, even though the ALU ignores it.
REQ-035 done and err SHALL never be high in the same cycle.

Reset
REQ-036 While rst_n = 0: state = IDLE, all register-file entries = 0, done = err = busy = 0, done_data = 0, and alu_* = 0.
REQ-037 instr_ready SHALL be 0 while rst_n = 0 and 1 in the first cycle after rst_n deasserts.
REQ-038 Reset asserted in ISSUE or CAPTURE SHALL abort the operation with no writeback and no done pulse.

Verification
REQ-039 ADD: preload r1 = 5, r2 = 7; issue funct 1, rd 3, rs 1, rt 2 -> alu_funct = 1 in ISSUE only; done at T+2; done_data = 12; r3 = 12.
REQ-040 SRA: preload r4 = 0x80000000; issue funct 8, rs 4, shamt 4, rd 5 -> done_data = 0xF8000000; then issue funct 9 (SRL) with the same operands -> done_data = 0x08000000.
REQ-041 Illegal funct: issue funct 12 -> err pulse at T+1 for one cycle; no done pulse; busy stays 0; instr_ready stays 1.
REQ-042 Chained instructions with instr_valid held high: r1 = 3; first instruction r1 = r1 + r1 (expect 6), second r1 = r1 - r1... substitute XOR with r2 = 0 preloaded -> accepts exactly 3 cycles apart; second operation sees r1 = 6.
REQ-043 ext_we pulsed in ISSUE (addr = rs, data = 99) -> ignored; result uses the original value; r[rs] is unchanged afterwards.
REQ-044 rst_n pulled low in CAPTURE -> no done pulse; all register-file entries = 0; instr_ready = 1 one cycle after release.
